sram_port_arbiter: RTL and testbench

//  Shares the single-port weight/bias/neuron SRAM between NUM_REQ requesters:
//   req0 host loader, req1 multiplier operand fetch, req2 ReLU/neuron writeback.

---
 rtl/sram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between NUM_REQ requesters.
// Arbitration is round-robin. A requester can hold a burst lock. The arbiter
// drives the SRAM command pins and returns 1-cycle-latency read data to the
// requester that issued the read.
//
// Handshake: req[i] means requester i has a valid request, and gnt[i] means
// the arbiter is ready for it. An access transfers in any cycle where both are
// high. A requester keeps we/addr/wdata/lock stable while req is high. It may
// cancel by dropping req. A read transferred in cycle T returns on rvalid[i]
// in cycle T+1, for exactly one cycle.
module sram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      sram_wr,
    output logic                      sram_rd,
    output logic [ADDR_W-1:0]         sram_adr,
    output logic [DATA_W-1:0]         sram_din,
    input  logic [DATA_W-1:0]         sram_dout,
    output logic [15:0]               conflicts,
    output logic                      busy,
    output logic                      dbg_locked_o,
    output logic [NUM_REQ-1:0]        dbg_lock_own_o,
    output logic [IDX_W-1:0]          dbg_rr_ptr_o
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]   own_q, own_d;        // one-hot lock owner
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
    logic [15:0]          conflicts_q, conflicts_d;
    logic [ADDR_W-1:0]    adr_q;
    logic [DATA_W-1:0]    din_q;

    logic [NUM_REQ-1:0]   gnt_rr;
    logic                 rr_found;
    int                   rr_idx;
    logic                 own_req;
    logic                 accept;
    logic                 we_sel;
    logic                 lock_sel;
    logic                 multi_req;
    logic [IDX_W-1:0]     gnt_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // Round-robin candidate: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_rr   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!rr_found && req[rr_idx]) begin
                gnt_rr[rr_idx] = 1'b1;
                rr_found       = 1'b1;
            end
        end
    end

    // Final grant: a requesting lock owner wins. Reset suppresses all grants.
    always_comb begin
        own_req = |(req & own_q);
        gnt     = '0;
        if (!rst) begin
            if ((state_q == ST_LOCKED) && own_req) begin
                gnt = own_q;
            end else begin
                gnt = gnt_rr;
            end
        end
    end

    // Mux the granted requester's command fields onto the SRAM side.
    always_comb begin
        accept    = |gnt;
        we_sel    = |(we & gnt);
        lock_sel  = |(lock & gnt);
        sel_addr  = '0;
        sel_wdata = '0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                gnt_idx   = IDX_W'(i);
            end
        end
    end

    assign sram_wr  = accept & we_sel;
    assign sram_rd  = accept & ~we_sel;
    // Address and data hold their last driven values while the port is idle.
    assign sram_adr = accept ? sel_addr  : adr_q;
    assign sram_din = accept ? sel_wdata : din_q;

    // Lock FSM and pointer next state. An accept decides the lock for the next
    // cycle. A locked cycle with no accept means the owner dropped its request.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (lock_sel) begin
                state_d = ST_LOCKED;
                own_d   = gnt;
            end else begin
                state_d  = ST_UNLOCKED;
                rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end else if (state_q == ST_LOCKED) begin
            state_d = ST_UNLOCKED;
        end
    end

    // Read-return tag and saturating conflict counter next state.
    always_comb begin
        rvalid_d    = (accept && !we_sel) ? gnt : '0;
        multi_req   = |(req & (req - NUM_REQ'(1)));
        conflicts_d = conflicts_q;
        if (multi_req && (conflicts_q != 16'hFFFF)) begin
            conflicts_d = conflicts_q + 16'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            own_q       <= '0;
            rr_ptr_q    <= '0;
            rvalid_q    <= '0;
            conflicts_q <= '0;
            adr_q       <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            rr_ptr_q    <= rr_ptr_d;
            rvalid_q    <= rvalid_d;
            conflicts_q <= conflicts_d;
            adr_q       <= sram_adr;
            din_q       <= sram_din;
        end
    end

    // While reset is high, any read still in flight is dropped.
    assign rvalid         = rst ? '0 : rvalid_q;
    assign rdata          = (|rvalid) ? sram_dout : '0;
    assign busy           = (|req) | (|rvalid);
    assign conflicts      = conflicts_q;
    assign dbg_locked_o   = (state_q == ST_LOCKED);
    assign dbg_lock_own_o = own_q;
    assign dbg_rr_ptr_o   = rr_ptr_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbiter/memory model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [2:0]  lock = '0;
  logic [8:0]  a_in[3];
  logic [31:0] d_in[3];
  logic [8:0]  nx_a[3];
  logic [31:0] nx_d[3];
  logic [26:0] addr;
  logic [95:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        sram_wr, sram_rd;
  logic [8:0]  sram_adr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;
  logic [15:0] conflicts;
  logic        busy;
  logic        dbg_locked;
  logic [2:0]  dbg_own;
  logic [2:0]  dbg_ptr;

  int n_checks = 0;
  int n_fail = 0;

  assign addr  = {a_in[2], a_in[1], a_in[0]};
  assign wdata = {d_in[2], d_in[1], d_in[0]};

  sram_port_arbiter #(.NUM_REQ(3), .ADDR_W(9), .DATA_W(32), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .sram_wr(sram_wr), .sram_rd(sram_rd),
    .sram_adr(sram_adr), .sram_din(sram_din), .sram_dout(sram_dout),
    .conflicts(conflicts), .busy(busy), .dbg_locked_o(dbg_locked),
    .dbg_lock_own_o(dbg_own), .dbg_rr_ptr_o(dbg_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM environment (1-cycle read latency) ----------------
  logic [31:0] sram_mem[512];
  always @(posedge clk) begin
    if (sram_wr) sram_mem[sram_adr] <= sram_din;
    if (sram_rd) sram_dout <= sram_mem[sram_adr];
  end

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] ref_mem[512];
  int          m_ptr = 0;
  bit          m_locked = 1'b0;
  int          m_own = 0;
  int          m_conf = 0;
  logic [2:0]  m_rv = '0;
  logic [8:0]  m_adr = '0;
  logic [31:0] m_din = '0;
  bit          m_hold_ok = 1'b0;
  logic [31:0] exp_q[$];   // read data in flight (at most one entry)
  int          m_g;

  // Index of the requester the rules say should win this cycle, or -1.
  function automatic int model_gidx(logic [2:0] r);
    if (m_locked && r[m_own]) return m_own;
    for (int k = 0; k < 3; k++) begin
      int i = (m_ptr + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_gnt();
    int g;
    if (rst) return 3'b000;
    g = model_gidx(req);
    return (g < 0) ? 3'b000 : (3'b001 << g);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_locked = 1'b0; m_own = 0; m_conf = 0;
      m_rv = '0; m_hold_ok = 1'b0;
      exp_q.delete();
    end else begin
      m_rv = '0;
      exp_q.delete();
      if ($countones(req) > 1 && m_conf < 65535) m_conf = m_conf + 1;
      m_g = model_gidx(req);
      if (m_g >= 0) begin
        m_adr = a_in[m_g];
        m_din = d_in[m_g];
        m_hold_ok = 1'b1;
        if (we[m_g]) begin
          ref_mem[a_in[m_g]] = d_in[m_g];
        end else begin
          m_rv[m_g] = 1'b1;
          exp_q.push_back(ref_mem[a_in[m_g]]);
        end
        if (lock[m_g]) begin
          m_locked = 1'b1;
          m_own = m_g;
        end else begin
          m_locked = 1'b0;
          m_ptr = (m_g + 1) % 3;
        end
      end else begin
        m_locked = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    @(negedge clk);
    req = r; we = w; lock = l;
    for (int i = 0; i < 3; i++) begin
      a_in[i] = nx_a[i];
      d_in[i] = nx_d[i];
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; we = '0; lock = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 3'b111; we = 3'b000; #1;
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b exp 000", gnt); end
    n_checks++; if ({sram_wr, sram_rd} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b exp 00", {sram_wr, sram_rd}); end
    @(negedge clk); #1;
    n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b exp 000", rvalid); end
    n_checks++; if (conflicts !== 16'd0) begin n_fail++; $display("FAIL reset_conflicts: got %0d exp 0", conflicts); end
    req = 3'b000; rst = 1'b0;
    drive(3'b000, 3'b000, 3'b000);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if ({dbg_locked, dbg_ptr} !== 4'b0000) begin n_fail++; $display("FAIL reset_state: got lock=%b ptr=%0d exp 0/0", dbg_locked, dbg_ptr); end
  endtask

  task automatic test_write_read();
    nx_a[0] = 9'd5; nx_d[0] = 32'hDEAD_BEEF;
    drive(3'b001, 3'b001, 3'b000);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL wr_gnt: got %b exp 001", gnt); end
    n_checks++; if ({sram_wr, sram_rd} !== 2'b10) begin n_fail++; $display("FAIL wr_strobes: got %b exp 10", {sram_wr, sram_rd}); end
    n_checks++; if (sram_adr !== 9'd5) begin n_fail++; $display("FAIL wr_adr: got %0d exp 5", sram_adr); end
    n_checks++; if (sram_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_din: got %h exp deadbeef", sram_din); end
    nx_a[1] = 9'd5;
    drive(3'b010, 3'b000, 3'b000);
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt: got %b exp 010", gnt); end
    n_checks++; if ({sram_wr, sram_rd} !== 2'b01) begin n_fail++; $display("FAIL rd_strobes: got %b exp 01", {sram_wr, sram_rd}); end
    n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL wr_no_rvalid: got %b exp 000", rvalid); end
    drive(3'b000, 3'b000, 3'b000);
    n_checks++; if (rvalid !== 3'b010) begin n_fail++; $display("FAIL rd_rvalid: got %b exp 010", rvalid); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h exp deadbeef", rdata); end
    n_checks++; if ({sram_wr, sram_rd, sram_adr} !== {2'b00, 9'd5}) begin n_fail++; $display("FAIL idle_hold: got wr=%b rd=%b adr=%0d exp 0 0 5", sram_wr, sram_rd, sram_adr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rvalid: got %b exp 1", busy); end
    drive(3'b000, 3'b000, 3'b000);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq[6];
    logic [2:0] prev;
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    prev = 3'b000;
    apply_reset();
    for (int i = 0; i < 3; i++) nx_a[i] = 9'(20 + i);
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 3'b000, 3'b000);
      n_checks++; if (gnt !== seq[i]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b exp %b", i, gnt, seq[i]); end
      n_checks++; if (rvalid !== prev) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b exp %b", i, rvalid, prev); end
      if (prev != 3'b000 && exp_q.size() > 0) begin
        n_checks++; if (rdata !== exp_q[0]) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h exp %h", i, rdata, exp_q[0]); end
      end
      prev = seq[i];
    end
    drive(3'b000, 3'b000, 3'b000);
    n_checks++; if (conflicts !== 16'd6) begin n_fail++; $display("FAIL rr_conflicts: got %0d exp 6", conflicts); end
    n_checks++; if (rvalid !== 3'b100) begin n_fail++; $display("FAIL rr_last_rvalid: got %b exp 100", rvalid); end
  endtask

  task automatic test_lock();
    apply_reset();
    drive(3'b001, 3'b000, 3'b000);   // moves the pointer to requester 1
    for (int i = 0; i < 3; i++) begin
      drive(3'b011, 3'b000, 3'b010);
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL lock_gnt[%0d]: got %b exp 010", i, gnt); end
    end
    drive(3'b011, 3'b000, 3'b000);
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL lock_last_gnt: got %b exp 010", gnt); end
    n_checks++; if (dbg_locked !== 1'b1) begin n_fail++; $display("FAIL lock_state: got %b exp 1", dbg_locked); end
    drive(3'b011, 3'b000, 3'b000);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL unlock_gnt: got %b exp 001", gnt); end
    n_checks++; if (dbg_locked !== 1'b0) begin n_fail++; $display("FAIL unlock_state: got %b exp 0", dbg_locked); end
  endtask

  task automatic test_lock_drop();
    apply_reset();
    nx_a[0] = 9'd3; nx_a[2] = 9'd7;
    drive(3'b100, 3'b000, 3'b100);
    drive(3'b101, 3'b000, 3'b100);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL drop_locked_gnt: got %b exp 100", gnt); end
    drive(3'b001, 3'b000, 3'b000);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL drop_gnt: got %b exp 001", gnt); end
    n_checks++; if ({sram_rd, sram_adr} !== {1'b1, 9'd3}) begin n_fail++; $display("FAIL drop_access: got rd=%b adr=%0d exp 1 3", sram_rd, sram_adr); end
    n_checks++; if (rvalid !== 3'b100) begin n_fail++; $display("FAIL drop_prev_rvalid: got %b exp 100", rvalid); end
    drive(3'b000, 3'b000, 3'b000);
    n_checks++; if (dbg_locked !== 1'b0) begin n_fail++; $display("FAIL drop_unlocked: got %b exp 0", dbg_locked); end
    n_checks++; if (rvalid !== 3'b001) begin n_fail++; $display("FAIL drop_rvalid: got %b exp 001", rvalid); end
    if (exp_q.size() > 0) begin
      n_checks++; if (rdata !== exp_q[0]) begin n_fail++; $display("FAIL drop_rdata: got %h exp %h", rdata, exp_q[0]); end
    end
  endtask

  task automatic test_reset_in_flight();
    apply_reset();
    drive(3'b111, 3'b000, 3'b000);
    drive(3'b111, 3'b000, 3'b000);
    drive(3'b010, 3'b000, 3'b000);   // read accepted in cycle T
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL flight_gnt: got %b exp 010", gnt); end
    @(negedge clk);
    rst = 1'b1; req = 3'b000; #1;
    n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL flight_rvalid_t1: got %b exp 000", rvalid); end
    @(negedge clk);
    rst = 1'b0; #1;
    n_checks++; if (rvalid !== 3'b000) begin n_fail++; $display("FAIL flight_rvalid_t2: got %b exp 000", rvalid); end
    n_checks++; if (conflicts !== 16'd0) begin n_fail++; $display("FAIL flight_conflicts: got %0d exp 0", conflicts); end
    n_checks++; if (dbg_ptr !== 3'd0) begin n_fail++; $display("FAIL flight_ptr: got %0d exp 0", dbg_ptr); end
    drive(3'b111, 3'b000, 3'b000);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL flight_gnt_after: got %b exp 001", gnt); end
  endtask

  task automatic test_random();
    bit          pend[3];
    logic [2:0]  pw, pl, r, w, l, eg;
    logic [8:0]  pa[3];
    logic [31:0] pd[3];
    int          g;
    apply_reset();
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    pw = '0; pl = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pw[i] = 1'($urandom_range(0, 1));
          pl[i] = ($urandom_range(0, 3) == 0);
          pa[i] = 9'($urandom_range(0, 15));
          pd[i] = $urandom;
        end
        r[i] = pend[i];
        w[i] = pend[i] & pw[i];
        l[i] = pend[i] & pl[i];
        nx_a[i] = pend[i] ? pa[i] : 9'd0;
        nx_d[i] = pend[i] ? pd[i] : 32'd0;
      end
      drive(r, w, l);
      eg = model_gnt();
      g = model_gidx(req);
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b exp %b", cyc, gnt, eg); end
      n_checks++; if ({sram_wr, sram_rd} !== ((g < 0) ? 2'b00 : {we[g], ~we[g]})) begin n_fail++; $display("FAIL rnd_strobes[%0d]: got %b%b", cyc, sram_wr, sram_rd); end
      if (g >= 0) begin
        n_checks++; if ({sram_adr, sram_din} !== {a_in[g], d_in[g]}) begin n_fail++; $display("FAIL rnd_cmd[%0d]: got %0d/%h exp %0d/%h", cyc, sram_adr, sram_din, a_in[g], d_in[g]); end
      end else if (m_hold_ok) begin
        n_checks++; if ({sram_adr, sram_din} !== {m_adr, m_din}) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %0d/%h exp %0d/%h", cyc, sram_adr, sram_din, m_adr, m_din); end
      end
      n_checks++; if (rvalid !== m_rv) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b exp %b", cyc, rvalid, m_rv); end
      if (m_rv != 3'b000 && exp_q.size() > 0) begin
        n_checks++; if (rdata !== exp_q[0]) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", cyc, rdata, exp_q[0]); end
      end
      n_checks++; if (conflicts !== 16'(m_conf)) begin n_fail++; $display("FAIL rnd_conflicts[%0d]: got %0d exp %0d", cyc, conflicts, m_conf); end
      n_checks++; if (busy !== ((|req) | (|m_rv))) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b", cyc, busy); end
      if (g >= 0) pend[g] = 1'b0;
    end
    drive(3'b000, 3'b000, 3'b000);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 3; i++) nx_a[i] = 9'd0;
    drive(3'b011, 3'b000, 3'b000);
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (conflicts !== 16'hFFFE) begin n_fail++; $display("FAIL sat_before: got %h exp fffe", conflicts); end
    repeat (4500) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (conflicts !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h exp ffff", conflicts); end
    n_checks++; if (conflicts !== 16'(m_conf)) begin n_fail++; $display("FAIL sat_model: got %h exp %h", conflicts, 16'(m_conf)); end
    req = 3'b000;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = init_word(i);
      ref_mem[i]  = init_word(i);
    end
    for (int i = 0; i < 3; i++) begin
      a_in[i] = '0; d_in[i] = '0; nx_a[i] = '0; nx_d[i] = '0;
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_lock_drop();
    test_reset_in_flight();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
